// File: rtl/ecc_run_ctrl.sv
// Run sequencer: holds the CPU while the loader fills IMEM, watches ECC status, reloads on
// uncorrectable errors. Define ECC_AUTO_RETRY_EN to enable the FLUSH/reload retry path.
module ecc_run_ctrl #(
    parameter int unsigned RETRY_MAX    = 3,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned LOAD_TIMEOUT = 64,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             loader_done,
    input  logic             imem_error,
    input  logic             dmem_error,
    input  logic [1:0]       error_type_imem,
    input  logic [1:0]       error_type_dmem,
    output logic             loader_run,
    output logic             cpu_run,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [1:0]       retry_cnt,
    output logic [CNT_W-1:0] corr_cnt_imem,
    output logic [CNT_W-1:0] corr_cnt_dmem,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_FAULT = 3'd4
    } state_t;

`ifdef ECC_AUTO_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int unsigned TMR_MAX    = (LOAD_TIMEOUT > FLUSH_CYCLES) ? LOAD_TIMEOUT : FLUSH_CYCLES;
    localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] LOAD_LAST  = TMR_W'(LOAD_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] FLUSH_LAST = TMR_W'(FLUSH_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIM  = 2'(RETRY_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_IMEM    = 2'b01;
    localparam logic [1:0] FC_DMEM    = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       retry_q, retry_d;
    logic [1:0]       fc_q, fc_d;
    logic [CNT_W-1:0] ci_q, ci_d;
    logic [CNT_W-1:0] cd_q, cd_d;
    logic             loader_run_q, cpu_run_q, busy_q, fault_q;

    // Bit 1 of the type marks an uncorrectable event; only 01 is a correction.
    logic unc_imem_c, unc_dmem_c, cor_imem_c, cor_dmem_c;
    assign unc_imem_c = imem_error & error_type_imem[1];
    assign unc_dmem_c = dmem_error & error_type_dmem[1];
    assign cor_imem_c = imem_error & (error_type_imem == 2'b01);
    assign cor_dmem_c = dmem_error & (error_type_dmem == 2'b01);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fc_d    = fc_q;
        ci_d    = ci_q;
        cd_d    = cd_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    retry_d = '0;
                    fc_d    = FC_NONE;
                end
            end
            S_LOAD: begin
                if (loader_done) begin
                    state_d = S_RUN;
                end else if (tmr_q == LOAD_LAST) begin
                    state_d = S_FAULT;
                    fc_d    = FC_TIMEOUT;
                end
            end
            S_RUN: begin
                if (cor_imem_c && (ci_q != CNT_SAT)) ci_d = ci_q + CNT_W'(1);
                if (cor_dmem_c && (cd_q != CNT_SAT)) cd_d = cd_q + CNT_W'(1);
                // An uncorrectable event overrides a concurrent stop.
                if (unc_imem_c || unc_dmem_c) begin
                    if (RETRY_EN && (retry_q < RETRY_LIM)) begin
                        retry_d = retry_q + 2'd1;
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_FAULT;
                        fc_d    = unc_imem_c ? FC_IMEM : FC_DMEM;
                    end
                end else if (stop) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (tmr_q == FLUSH_LAST) state_d = S_LOAD;
            end
            S_FAULT: begin
                if (clear) begin
                    state_d = S_IDLE;
                    fc_d    = FC_NONE;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            ci_d = '0;
            cd_d = '0;
        end

        // Timer restarts on every state change, so LOAD and FLUSH each count from 0.
        tmr_d = (state_d == state_q) ? tmr_q + TMR_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            retry_q      <= '0;
            fc_q         <= FC_NONE;
            ci_q         <= '0;
            cd_q         <= '0;
            loader_run_q <= 1'b0;
            cpu_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            retry_q      <= retry_d;
            fc_q         <= fc_d;
            ci_q         <= ci_d;
            cd_q         <= cd_d;
            loader_run_q <= (state_d == S_LOAD) || (state_d == S_RUN);
            cpu_run_q    <= (state_d == S_RUN);
            busy_q       <= (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_FLUSH);
            fault_q      <= (state_d == S_FAULT);
        end
    end

    assign loader_run    = loader_run_q;
    assign cpu_run       = cpu_run_q;
    assign busy          = busy_q;
    assign fault         = fault_q;
    assign fault_code    = fc_q;
    assign retry_cnt     = retry_q;
    assign corr_cnt_imem = ci_q;
    assign corr_cnt_dmem = cd_q;
    assign state         = state_q;

endmodule

// File: tb/tb_ecc_run_ctrl.sv
// Self-checking bench for ecc_run_ctrl: vector table, directed corner sequences and a
// randomized run against a cycle-level reference model.
module tb_ecc_run_ctrl;

    localparam int RETRY_MAX    = 3;
    localparam int CNT_W        = 4;
    localparam int LOAD_TIMEOUT = 64;
    localparam int FLUSH_CYCLES = 4;
    localparam int CMAX         = (1 << CNT_W) - 1;

`ifdef ECC_AUTO_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    localparam int ST_IDLE = 0, ST_LOAD = 1, ST_RUN = 2, ST_FLUSH = 3, ST_FAULT = 4;

    logic             clk = 1'b0;
    logic             rst, start, stop, clear, loader_done, imem_error, dmem_error;
    logic [1:0]       error_type_imem, error_type_dmem;
    logic             loader_run, cpu_run, busy, fault;
    logic [1:0]       fault_code, retry_cnt;
    logic [CNT_W-1:0] corr_cnt_imem, corr_cnt_dmem;
    logic [2:0]       state;

    always #5 clk = ~clk;

    ecc_run_ctrl #(
        .RETRY_MAX   (RETRY_MAX),
        .CNT_W       (CNT_W),
        .LOAD_TIMEOUT(LOAD_TIMEOUT),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .clear          (clear),
        .loader_done    (loader_done),
        .imem_error     (imem_error),
        .dmem_error     (dmem_error),
        .error_type_imem(error_type_imem),
        .error_type_dmem(error_type_dmem),
        .loader_run     (loader_run),
        .cpu_run        (cpu_run),
        .busy           (busy),
        .fault          (fault),
        .fault_code     (fault_code),
        .retry_cnt      (retry_cnt),
        .corr_cnt_imem  (corr_cnt_imem),
        .corr_cnt_dmem  (corr_cnt_dmem),
        .state          (state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: state by name, time in state measured as edges since entry.
    int m_state, m_fc, m_retry, m_ci, m_cd;
    int m_cyc   = 0;
    int m_entry = 0;

    task automatic model_step();
        int nxt;
        bit ui, ud;
        m_cyc++;
        if (rst) begin
            m_state = ST_IDLE; m_fc = 0; m_retry = 0; m_ci = 0; m_cd = 0; m_entry = m_cyc;
            return;
        end
        ui  = imem_error && (error_type_imem >= 2'd2);
        ud  = dmem_error && (error_type_dmem >= 2'd2);
        nxt = m_state;
        case (m_state)
            ST_IDLE: if (start) begin nxt = ST_LOAD; m_retry = 0; m_fc = 0; end
            ST_LOAD: begin
                if (loader_done) nxt = ST_RUN;
                else if (m_cyc - m_entry == LOAD_TIMEOUT) begin nxt = ST_FAULT; m_fc = 3; end
            end
            ST_RUN: begin
                if (imem_error && error_type_imem == 2'd1 && m_ci < CMAX) m_ci++;
                if (dmem_error && error_type_dmem == 2'd1 && m_cd < CMAX) m_cd++;
                if (ui || ud) begin
                    if (RETRY_ON && m_retry < RETRY_MAX) begin m_retry++; nxt = ST_FLUSH; end
                    else begin nxt = ST_FAULT; m_fc = ui ? 1 : 2; end
                end else if (stop) begin
                    nxt = ST_IDLE;
                end
            end
            ST_FLUSH: if (m_cyc - m_entry == FLUSH_CYCLES) nxt = ST_LOAD;
            ST_FAULT: if (clear) begin nxt = ST_IDLE; m_fc = 0; m_retry = 0; end
            default: ;
        endcase
        if (clear) begin m_ci = 0; m_cd = 0; end
        if (nxt != m_state) m_entry = m_cyc;
        m_state = nxt;
    endtask

    function automatic logic [18:0] model_vec();
        logic lr, cr, bz, ft;
        lr = (m_state == ST_LOAD) || (m_state == ST_RUN);
        cr = (m_state == ST_RUN);
        bz = (m_state == ST_LOAD) || (m_state == ST_RUN) || (m_state == ST_FLUSH);
        ft = (m_state == ST_FAULT);
        return {3'(m_state), 2'(m_fc), 2'(m_retry), lr, cr, bz, ft, 4'(m_ci), 4'(m_cd)};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {state, fault_code, retry_cnt, loader_run, cpu_run, busy, fault,
                corr_cnt_imem, corr_cnt_dmem};
    endfunction

    task automatic drv(input int r, input int s, input int p, input int c, input int d,
                       input int ie, input int ti, input int de, input int td);
        rst = 1'(r); start = 1'(s); stop = 1'(p); clear = 1'(c); loader_done = 1'(d);
        imem_error = 1'(ie); error_type_imem = 2'(ti);
        dmem_error = 1'(de); error_type_dmem = 2'(td);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk($sformatf("model_cyc%0d", m_cyc), 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic idle_steps(input int n);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

`ifdef ECC_AUTO_RETRY_EN
    task automatic retry_round(input int k);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 2); step();
        chk("retry_flush_state", 32'(state), ST_FLUSH);
        chk("retry_cnt", 32'(retry_cnt), k);
        chk("retry_cpu_low", 32'(cpu_run), 0);
        idle_steps(FLUSH_CYCLES - 1);
        chk("flush_hold", 32'(state), ST_FLUSH);
        idle_steps(1);
        chk("flush_to_load", 32'(state), ST_LOAD);
        drv(0, 0, 0, 0, 1, 0, 0, 0, 0); step();
        chk("reload_run", 32'(state), ST_RUN);
    endtask
`endif

    typedef struct {
        int rst, start, stop, clr, done, ie, ti, de, td;
        int st, lr, cr, ci, cd, fc;
    } vec_t;
    vec_t tbl[16];

    initial begin
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //          rst st sp cl dn ie ti de td | st lr cr ci cd fc
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0,   2, 1, 1, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0,   2, 1, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1,   2, 1, 1, 2, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 3, 1, 0,   2, 1, 1, 2, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, 2,   2, 1, 1, 2, 1, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0,   2, 1, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1,   2, 1, 1, 0, 1, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 1, 0};
        tbl[12] = '{0, 1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 1, 3, 1, 2,   1, 1, 0, 0, 1, 0};
        tbl[14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0,   2, 1, 1, 0, 1, 0};
        tbl[15] = '{0, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0};

        for (int i = 0; i < 16; i++) begin
            drv(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].clr, tbl[i].done,
                tbl[i].ie, tbl[i].ti, tbl[i].de, tbl[i].td);
            step();
            chk($sformatf("tbl%0d_state", i), 32'(state), tbl[i].st);
            chk($sformatf("tbl%0d_loader_run", i), 32'(loader_run), tbl[i].lr);
            chk($sformatf("tbl%0d_cpu_run", i), 32'(cpu_run), tbl[i].cr);
            chk($sformatf("tbl%0d_ci", i), 32'(corr_cnt_imem), tbl[i].ci);
            chk($sformatf("tbl%0d_cd", i), 32'(corr_cnt_dmem), tbl[i].cd);
            chk($sformatf("tbl%0d_fc", i), 32'(fault_code), tbl[i].fc);
        end

        // Reset, start, loader_done after 10 cycles.
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("reset_vec", 32'(dut_vec()), 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0); step();
        chk("start_load", 32'(state), ST_LOAD);
        chk("start_loader_run", 32'(loader_run), 1);
        idle_steps(10);
        chk("load_cpu_held", 32'(cpu_run), 0);
        drv(0, 0, 0, 0, 1, 0, 0, 0, 0); step();
        chk("done_cpu_run", 32'(cpu_run), 1);
        chk("done_state", 32'(state), ST_RUN);
        chk("done_busy", 32'(busy), 1);

        // 5 IMEM + 3 DMEM corrections, two coincident.
        drv(0, 0, 0, 1, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 0, 0, 1, 1, 1, 1); step(); step();
        drv(0, 0, 0, 0, 0, 1, 1, 0, 0); step(); step(); step();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1); step();
        chk("corr_imem5", 32'(corr_cnt_imem), 5);
        chk("corr_dmem3", 32'(corr_cnt_dmem), 3);
        chk("corr_still_run", 32'(state), ST_RUN);

        // Saturation, then clear beats a same-cycle increment.
        drv(0, 0, 0, 1, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 0, 0, 1, 1, 0, 0); repeat (20) step();
        chk("corr_saturate", 32'(corr_cnt_imem), 15);
        drv(0, 0, 0, 1, 0, 1, 1, 0, 0); step();
        chk("clear_wins", 32'(corr_cnt_imem), 0);

        // DMEM uncorrectable sequence.
`ifdef ECC_AUTO_RETRY_EN
        for (int k = 1; k <= RETRY_MAX; k++) retry_round(k);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 2); step();
        chk("retry_exhaust_fault", 32'(state), ST_FAULT);
        chk("retry_exhaust_code", 32'(fault_code), 2);
        chk("retry_exhaust_cnt", 32'(retry_cnt), 3);
`else
        drv(0, 0, 0, 0, 0, 0, 0, 1, 2); step();
        chk("dmem_unc_fault", 32'(state), ST_FAULT);
        chk("dmem_unc_code", 32'(fault_code), 2);
        chk("dmem_unc_retry0", 32'(retry_cnt), 0);
`endif
        chk("fault_flag", 32'(fault), 1);
        chk("fault_outputs_low", 32'({loader_run, cpu_run, busy}), 0);
        drv(0, 0, 0, 1, 0, 0, 0, 0, 0); step();
        chk("fault_clear_idle", 32'(state), ST_IDLE);

        // Coincident IMEM/DMEM uncorrectable: IMEM wins the code.
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 0, 1, 0, 0, 0, 0); step();
`ifdef ECC_AUTO_RETRY_EN
        for (int k = 1; k <= RETRY_MAX; k++) retry_round(k);
`endif
        drv(0, 0, 0, 0, 0, 1, 2, 1, 3); step();
        chk("both_unc_fault", 32'(state), ST_FAULT);
        chk("both_unc_code", 32'(fault_code), 1);
        drv(0, 0, 0, 1, 0, 0, 0, 0, 0); step();
        chk("clear_state", 32'(state), ST_IDLE);
        chk("clear_fault", 32'(fault), 0);
        chk("clear_retry", 32'(retry_cnt), 0);
        chk("clear_code", 32'(fault_code), 0);

        // Load timeout: FAULT exactly LOAD_TIMEOUT cycles after LOAD entry.
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0); step();
        idle_steps(LOAD_TIMEOUT - 1);
        chk("timeout_not_yet", 32'(state), ST_LOAD);
        idle_steps(1);
        chk("timeout_fault", 32'(state), ST_FAULT);
        chk("timeout_code", 32'(fault_code), 3);
        drv(0, 0, 0, 1, 0, 0, 0, 0, 0); step();

        // loader_done on the timeout cycle wins.
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0); step();
        idle_steps(LOAD_TIMEOUT - 1);
        drv(0, 0, 0, 0, 1, 0, 0, 0, 0); step();
        chk("done_on_timeout", 32'(state), ST_RUN);
        chk("done_on_timeout_code", 32'(fault_code), 0);

        // stop with a same-cycle uncorrectable event: error wins.
        drv(0, 0, 1, 0, 0, 1, 2, 0, 0); step();
`ifdef ECC_AUTO_RETRY_EN
        chk("stop_vs_err", 32'(state), ST_FLUSH);
        idle_steps(FLUSH_CYCLES);
`else
        chk("stop_vs_err", 32'(state), ST_FAULT);
        drv(0, 0, 0, 1, 0, 0, 0, 0, 0); step();
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0); step();
`endif
        drv(0, 0, 0, 0, 1, 1, 1, 0, 0); step();
        drv(0, 0, 0, 0, 0, 1, 1, 0, 0); step();
        chk("pre_rst_run", 32'(state), ST_RUN);

        // Reset mid-RUN.
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0); step();
        chk("rst_mid_run", 32'(dut_vec()), 0);

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            drv(int'($urandom_range(499) == 0), int'($urandom_range(2) == 0),
                int'($urandom_range(29) == 0), int'($urandom_range(59) == 0),
                int'($urandom_range(49) == 0),
                int'($urandom_range(5) == 0), int'($urandom_range(3)),
                int'($urandom_range(5) == 0), int'($urandom_range(3)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
